// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the fetch-master data-phase state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_FETCH   = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_ERR  = 2'b10
  } fetch_st_t;

endpackage

// File: rtl/ahb_ri5cy_fetch_master.sv
// RI5CY instruction-fetch (req/gnt/rvalid) to AHB-Lite master with pipelined address/data phases.
// Define RI5CY_FETCH_ERR_EN to report bus errors on instr_err_o; otherwise errors return a jal x0,0 self-loop.
module ahb_ri5cy_fetch_master
  import ahb_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      instr_req_i,
  input  logic [AHB_ADDR_WIDTH-1:0] instr_addr_i,
  output logic                      instr_gnt_o,
  output logic                      instr_rvalid_o,
  output logic [AHB_DATA_WIDTH-1:0] instr_rdata_o,
  output logic                      instr_err_o,
  output logic [AHB_ADDR_WIDTH-1:0] haddr_o,
  output logic [1:0]                htrans_o,
  output logic                      hwrite_o,
  output logic [2:0]                hsize_o,
  output logic [2:0]                hburst_o,
  output logic [3:0]                hprot_o,
  output logic                      hmastlock_o,
  output logic [AHB_DATA_WIDTH-1:0] hwdata_o,
  input  logic [AHB_DATA_WIDTH-1:0] hrdata_i,
  input  logic                      hready_i,
  input  logic                      hresp_i
);

`ifdef RI5CY_FETCH_ERR_EN
  localparam logic [AHB_DATA_WIDTH-1:0] ERR_RDATA = '0;
`else
  localparam logic [AHB_DATA_WIDTH-1:0] ERR_RDATA = AHB_DATA_WIDTH'(32'h0000_006F);
`endif

  logic [AHB_ADDR_WIDTH-1:0] addr_q;
  logic                      addr_v;
  fetch_st_t                 state;
  logic                      rvalid_q;
  logic [AHB_DATA_WIDTH-1:0] rdata_q;

  logic not_err, addr_done, data_done, ok_beat, err_beat;

  assign not_err   = (state != ST_ERR);
  assign addr_done = addr_v & hready_i & not_err;
  assign data_done = (state == ST_DATA) & hready_i;
  assign ok_beat   = data_done & ~hresp_i;
  // A one-cycle ERROR (hready high with hresp) is illegal AHB, but is still reported as an error beat.
  assign err_beat  = ((state == ST_ERR) & hready_i) | (data_done & hresp_i);

  assign instr_gnt_o = instr_req_i & (~addr_v | (hready_i & not_err));

  assign haddr_o     = addr_q & ~AHB_ADDR_WIDTH'(3);
  assign htrans_o    = (addr_v & not_err) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hwrite_o    = 1'b0;
  assign hsize_o     = HSIZE_WORD;
  assign hburst_o    = HBURST_SINGLE;
  assign hprot_o     = HPROT_FETCH;
  assign hmastlock_o = 1'b0;
  assign hwdata_o    = '0;

  assign instr_rvalid_o = rvalid_q;
  assign instr_rdata_o  = rdata_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q <= '0;
      addr_v <= 1'b0;
    end else if (instr_gnt_o) begin
      addr_q <= instr_addr_i;
      addr_v <= 1'b1;
    end else if (addr_done) begin
      addr_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (addr_done) state <= ST_DATA;
        ST_DATA: begin
          if (hready_i)     state <= addr_done ? ST_DATA : ST_IDLE;
          else if (hresp_i) state <= ST_ERR;
        end
        ST_ERR:  if (hready_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= ok_beat | err_beat;
      rdata_q  <= ok_beat ? hrdata_i : (err_beat ? ERR_RDATA : '0);
    end
  end

`ifdef RI5CY_FETCH_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= err_beat;
  end
  assign instr_err_o = err_q;
`else
  assign instr_err_o = 1'b0;
`endif

endmodule
